// File: rtl/fifo_generator_0_pkg.sv
// Shared defaults and derived widths for the single-clock FIFO.
package fifo_generator_0_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefDepth     = 16;
    localparam int unsigned DefAddrWidth = $clog2(DefDepth);

    // Pointer width carries one extra wrap bit above the address.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_generator_0_ram.sv
// Simple dual-port storage: synchronous write, registered read with a clearable output register.
module fifo_generator_0_ram
    import fifo_generator_0_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned DEPTH      = DefDepth,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register only loads on an accepted read, so it holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_generator_0.sv
// Single-clock FIFO with registered flags, occupancy count and overflow/underflow pulses.
module fifo_generator_0
    import fifo_generator_0_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned DEPTH      = DefDepth,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned PW        = ptr_width(DEPTH)
) (
    input  logic                  wr_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic [PW-1:0]         data_count,
    output logic                  overflow,
    output logic                  underflow
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_accept;
    logic          rd_accept;

    always_comb begin
        // Acceptance uses the registered flags, so a full FIFO still takes a read.
        wr_accept   = wr_en & ~full_q & ~rst;
        rd_accept   = rd_en & ~empty_q & ~rst;
        wr_ptr_d    = wr_ptr_q + PW'(wr_accept);
        rd_ptr_d    = rd_ptr_q + PW'(rd_accept);
        full_d      = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
        empty_d     = (wr_ptr_d == rd_ptr_d);
        count_d     = wr_ptr_d - rd_ptr_d;
        overflow_d  = wr_en & full_q;
        underflow_d = rd_en & empty_q;
    end

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_generator_0_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (wr_clk),
        .rst   (rst),
        .we    (wr_accept),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (din),
        .re    (rd_accept),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (dout)
    );

    assign full       = full_q;
    assign empty      = empty_q;
    assign data_count = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_generator_0.sv
// Bench for fifo_generator_0: directed scenarios plus random traffic against a queue model.
module tb_fifo_generator_0;

    localparam int unsigned DW = 8;
    localparam int unsigned DP = 16;

    logic          wr_clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          wr_en;
    logic          full;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          empty;
    logic [4:0]    data_count;
    logic          overflow;
    logic          underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of stored words plus the expected registered outputs.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_ovf  = 1'b0;
    logic          m_udf  = 1'b0;

    always #5 wr_clk = ~wr_clk;

    fifo_generator_0 #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP)
    ) dut (
        .wr_clk     (wr_clk),
        .rst        (rst),
        .din        (din),
        .wr_en      (wr_en),
        .full       (full),
        .rd_en      (rd_en),
        .dout       (dout),
        .empty      (empty),
        .data_count (data_count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    // Advance the model by the rules of one rising edge, then let the edge happen.
    task automatic tick();
        bit was_full;
        bit was_empty;
        if (rst) begin
            q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            was_full  = (q.size() == DP);
            was_empty = (q.size() == 0);
            m_ovf = wr_en && was_full;
            m_udf = rd_en && was_empty;
            if (rd_en && !was_empty) m_dout = q.pop_front();
            if (wr_en && !was_full) q.push_back(din);
        end
        @(posedge wr_clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 8'hA5;
        tick();
        tick();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        checks += 6;
        if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b want=1", empty); end
        if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b want=0", full); end
        if (data_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", data_count); end
        if (dout !== 8'd0) begin failures++; $display("FAIL reset_dout got=%0d want=0", dout); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b want=0", overflow); end
        if (underflow !== 1'b0) begin failures++; $display("FAIL reset_udf got=%0b want=0", underflow); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            din = DW'(i); wr_en = 1'b1;
            tick();
            checks++;
            if (data_count !== 5'(i)) begin
                failures++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, data_count, i);
            end
        end
        checks += 2;
        if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%0b want=1", full); end
        if (empty !== 1'b0) begin failures++; $display("FAIL fill_empty got=%0b want=0", empty); end
        din = 8'd17;
        tick();
        wr_en = 1'b0;
        checks += 2;
        if (overflow !== 1'b1) begin failures++; $display("FAIL fill_ovf got=%0b want=1", overflow); end
        if (data_count !== 5'd16) begin
            failures++; $display("FAIL fill_ovf_count got=%0d want=16", data_count);
        end
        tick();
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL fill_ovf_pulse got=%0b want=0", overflow); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            rd_en = 1'b1;
            tick();
            checks++;
            if (dout !== DW'(i)) begin
                failures++; $display("FAIL drain_dout[%0d] got=%0d want=%0d", i, dout, i);
            end
        end
        checks += 2;
        if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%0b want=1", empty); end
        if (data_count !== 5'd0) begin failures++; $display("FAIL drain_count got=%0d want=0", data_count); end
        tick();
        rd_en = 1'b0;
        checks += 2;
        if (underflow !== 1'b1) begin failures++; $display("FAIL drain_udf got=%0b want=1", underflow); end
        if (dout !== 8'd16) begin failures++; $display("FAIL drain_hold got=%0d want=16", dout); end
        tick();
        checks++;
        if (underflow !== 1'b0) begin failures++; $display("FAIL drain_udf_pulse got=%0b want=0", underflow); end
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 50; k++) begin
            din = DW'(k + 3); wr_en = 1'b1; rd_en = 1'b1;
            tick();
            checks += 2;
            if (data_count > 5'd1) begin
                failures++; $display("FAIL stream_count[%0d] got=%0d want<=1", k, data_count);
            end
            if (k == 0) begin
                if (underflow !== 1'b1) begin
                    failures++; $display("FAIL stream_first_udf got=%0b want=1", underflow);
                end
            end else if (dout !== DW'(k + 2)) begin
                failures++; $display("FAIL stream_dout[%0d] got=%0d want=%0d", k, dout, k + 2);
            end
        end
        wr_en = 1'b0;
        tick();
        rd_en = 1'b0;
        checks += 2;
        if (dout !== 8'd52) begin failures++; $display("FAIL stream_last got=%0d want=52", dout); end
        if (empty !== 1'b1) begin failures++; $display("FAIL stream_empty got=%0b want=1", empty); end
    endtask

    task automatic test_boundary();
        wr_en = 1'b1; rd_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            din = DW'($urandom);
            tick();
        end
        rd_en = 1'b1; din = 8'hEE;
        tick();
        checks += 3;
        if (data_count !== 5'd15) begin failures++; $display("FAIL bnd_full_count got=%0d want=15", data_count); end
        if (full !== 1'b0) begin failures++; $display("FAIL bnd_full_flag got=%0b want=0", full); end
        if (overflow !== 1'b1) begin failures++; $display("FAIL bnd_full_ovf got=%0b want=1", overflow); end
        wr_en = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (dout !== m_dout) begin
                failures++; $display("FAIL bnd_drain[%0d] got=%0h want=%0h", i, dout, m_dout);
            end
        end
        wr_en = 1'b1; din = 8'h5C;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks += 3;
        if (data_count !== 5'd1) begin failures++; $display("FAIL bnd_empty_count got=%0d want=1", data_count); end
        if (empty !== 1'b0) begin failures++; $display("FAIL bnd_empty_flag got=%0b want=0", empty); end
        if (underflow !== 1'b1) begin failures++; $display("FAIL bnd_empty_udf got=%0b want=1", underflow); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (dout !== 8'h5C) begin failures++; $display("FAIL bnd_single got=%0h want=5c", dout); end
    endtask

    task automatic test_mid_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = DW'(8'h80 + i);
            tick();
        end
        rst = 1'b1; din = 8'h77;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        checks += 3;
        if (empty !== 1'b1) begin failures++; $display("FAIL mrst_empty got=%0b want=1", empty); end
        if (data_count !== 5'd0) begin failures++; $display("FAIL mrst_count got=%0d want=0", data_count); end
        if (dout !== 8'd0) begin failures++; $display("FAIL mrst_dout got=%0h want=0", dout); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks += 2;
        if (underflow !== 1'b1) begin failures++; $display("FAIL mrst_udf got=%0b want=1", underflow); end
        if (dout !== 8'd0) begin failures++; $display("FAIL mrst_stale got=%0h want=0", dout); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(63) == 0);
            wr_en = ($urandom_range(99) < 55);
            rd_en = ($urandom_range(99) < 45);
            din   = DW'($urandom);
            tick();
            checks += 6;
            if (dout !== m_dout) begin
                failures++; $display("FAIL rnd_dout[%0d] got=%0h want=%0h", c, dout, m_dout);
            end
            if (data_count !== 5'(q.size())) begin
                failures++; $display("FAIL rnd_count[%0d] got=%0d want=%0d", c, data_count, q.size());
            end
            if (full !== (q.size() == DP)) begin
                failures++; $display("FAIL rnd_full[%0d] got=%0b want=%0b", c, full, q.size() == DP);
            end
            if (empty !== (q.size() == 0)) begin
                failures++; $display("FAIL rnd_empty[%0d] got=%0b want=%0b", c, empty, q.size() == 0);
            end
            if (overflow !== m_ovf) begin
                failures++; $display("FAIL rnd_ovf[%0d] got=%0b want=%0b", c, overflow, m_ovf);
            end
            if (underflow !== m_udf) begin
                failures++; $display("FAIL rnd_udf[%0d] got=%0b want=%0b", c, underflow, m_udf);
            end
        end
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        test_reset();
        test_fill();
        test_drain();
        test_streaming();
        test_boundary();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_generator_0.md
FIFO_GENERATOR_0 -- requirements
Module: fifo_generator_0

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of din/dout.
REQ-002 Parameter DEPTH, default 16, SHALL set storage in words; power of two, >= 4.
REQ-003 wr_clk  input  1  SHALL be the single clock for all logic; write and read ports share it, and there is no rd_clk port.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 din  input  DATA_WIDTH  SHALL carry write data.
REQ-006 wr_en  input  1  SHALL be the write request.
REQ-007 full  output  1  SHALL mean no free entries remain.
REQ-008 rd_en  input  1  SHALL be the read request.
REQ-009 dout  output  DATA_WIDTH  SHALL carry read data.
REQ-010 empty  output  1  SHALL mean no stored entries remain.
REQ-011 data_count  output  $clog2(DEPTH)+1  SHALL give the current occupancy, 0..DEPTH.
REQ-012 overflow  output  1  SHALL pulse one cycle when a write is rejected.
REQ-013 underflow  output  1  SHALL pulse one cycle when a read is rejected.

Function
REQ-014 A write SHALL be accepted on a wr_clk rising edge when wr_en=1 and full=0; din is stored at the write pointer, which then advances.
REQ-015 A read SHALL be accepted on a rising edge when rd_en=1 and empty=0; dout SHALL present the oldest word one cycle after the accepting edge (standard mode, registered output).
REQ-016 dout SHALL hold its last value when no read is accepted.
REQ-017 Pointers SHALL be $clog2(DEPTH)+1 bits wide, with MSB wrap; full SHALL be (addresses equal, MSBs differ); empty SHALL be (pointers equal).
REQ-018 full, empty and data_count SHALL be registered and SHALL update on the same edge that accepts the write or read.
REQ-019 wr_en=1 while full SHALL leave memory and pointers unchanged and SHALL assert overflow the next cycle.
REQ-020 rd_en=1 while empty SHALL leave pointers and dout unchanged and SHALL assert underflow the next cycle.
REQ-021 Simultaneous accepted read and write SHALL leave data_count, full and empty unchanged.
REQ-022 When full, a simultaneous wr_en and rd_en SHALL accept only the read; the write is rejected with overflow, and full deasserts.
REQ-023 When empty, a simultaneous wr_en and rd_en SHALL accept only the write; the read is rejected with underflow, and empty deasserts.
REQ-024 Data order SHALL be strict first-in first-out across pointer wrap-around.

Reset
REQ-025 While rst=1 at a rising edge, the pointers and data_count SHALL clear to 0, empty=1, full=0, overflow=0, underflow=0 and dout=0.
REQ-026 Reset asserted mid-operation SHALL discard all stored data; memory contents need not clear.
REQ-027 wr_en and rd_en SHALL be ignored during any cycle in which rst=1.

Structure
REQ-028 A package fifo_generator_0_pkg SHALL hold the DATA_WIDTH and DEPTH defaults and the derived address-width constant.
REQ-029 Storage SHALL be one sub-module, fifo_generator_0_ram: simple dual-port, synchronous write, registered read, inferable as block or distributed RAM.
REQ-030 Flag and pointer logic SHALL live in the top module.

Verification
REQ-031 Reset: after rst=1 for 2 cycles then 0 -> empty=1, full=0, data_count=0, dout=0.
REQ-032 Fill: write 1..16 on consecutive cycles -> full=1 after the 16th edge, data_count=16; a 17th write -> overflow pulse, and the data is not stored.
REQ-033 Drain: read 16 times -> dout = 1..16 in order, each 1 cycle after its rd_en edge; empty=1 after the 16th read; a 17th read -> underflow pulse, and dout stays at 16.
REQ-034 Streaming: a counter on din with wr_en=1 and rd_en=1 continuously from empty -> dout follows din with a fixed latency, data_count stays at most 1, and 40+ words pass through wrap without loss.
REQ-035 Boundary: simultaneous wr_en and rd_en when full -> data_count goes to 15 and full=0; when empty -> data_count goes to 1, empty=0 and underflow=1.
REQ-036 Mid-operation reset: write 5 words, then rst=1 -> empty=1 and data_count=0; a following read -> underflow, and no old data appears.
